// File: rtl/nasti_narrower_pkg.sv
// Shared definitions for the NASTI narrower writer/reader datapaths.
//   - state_e        : splitter FSM states
//   - bytes_log2     : log2 of a bus width in bytes (gives SC / MC)
//   - slave_size     : per-narrow-beat size, min(size, sc)
//   - slave_step     : byte increment between narrow beats
//   - need_new_beat  : does the next narrow address start a new wide beat
// Address helpers only look at the low 8 address bits: a 3-bit size can
// span at most 128 bytes, so no higher bit ever matters.
package nasti_narrower_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_e;

    function automatic int bytes_log2(input int width_bits);
        return $clog2(width_bits / 8);
    endfunction

    function automatic logic [2:0] slave_size(input logic [2:0] size, input int sc);
        if (int'(size) > sc) return 3'(sc);
        return size;
    endfunction

    function automatic logic [7:0] slave_step(input logic [2:0] size, input int sc);
        return 8'd1 << slave_size(size, sc);
    endfunction

    // A wide beat holding several narrow lanes is exhausted once the next
    // address wraps back to the first narrow lane inside the wide beat.
    function automatic logic need_new_beat(input logic [7:0] addr_lo,
                                           input logic [2:0] size,
                                           input int         sc);
        logic [7:0] mask;
        if (int'(size) <= sc) return 1'b1;
        mask = ((8'd1 << size) - 8'd1) & ~((8'd1 << sc) - 8'd1);
        return (addr_lo & mask) == 8'd0;
    endfunction

endpackage

// File: rtl/nasti_lane_select.sv
// Combinational lane slicer: picks one OUT_W-bit lane (and its strobes)
// out of an IN_W-bit wide word.
//   in_data/in_strb   : wide word and its byte strobes
//   lane              : lane index (LSB lane = 0)
//   out_data/out_strb : selected lane
module nasti_lane_select #(
    parameter int IN_W   = 64,
    parameter int OUT_W  = 32,
    parameter int LANE_W = 1
) (
    input  logic [IN_W-1:0]    in_data,
    input  logic [IN_W/8-1:0]  in_strb,
    input  logic [LANE_W-1:0]  lane,
    output logic [OUT_W-1:0]   out_data,
    output logic [OUT_W/8-1:0] out_strb
);
    localparam int NL = IN_W / OUT_W;
    localparam int OB = OUT_W / 8;

    always_comb begin
        out_data = '0;
        out_strb = '0;
        for (int i = 0; i < NL; i++) begin
            if (lane == LANE_W'(i)) begin
                out_data = in_data[i*OUT_W +: OUT_W];
                out_strb = in_strb[i*OB +: OB];
            end
        end
    end

endmodule

// File: rtl/nasti_narrower_w_splitter.sv
// Write-data splitter for the NASTI narrower: takes one command per burst
// (start address, master beat size, slave beat count - 1) and turns wide
// master W beats into narrow slave W beats.
//   cmd_*      : burst command, accepted only while idle
//   master_w_* : wide W channel in (one beat held at a time)
//   slave_w_*  : narrow W channel out, driven only from the hold register
//   proto_err  : sticky master_w_last mismatch flag
// Optional feature: define NASTI_NARROWER_W_CHECK_EN to enable the
// master_w_last consistency check; otherwise proto_err is tied to 0.
// The slave burst length comes only from cmd_len; master_w_last never
// changes it. ADDR_WIDTH must be at least 8.
module nasti_narrower_w_splitter
    import nasti_narrower_pkg::*;
#(
    parameter int ADDR_WIDTH        = 32,
    parameter int MASTER_DATA_WIDTH = 64,
    parameter int SLAVE_DATA_WIDTH  = 32,
    parameter int USER_WIDTH        = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ADDR_WIDTH-1:0]          cmd_addr,
    input  logic [2:0]                     cmd_size,
    input  logic [7:0]                     cmd_len,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [MASTER_DATA_WIDTH-1:0]   master_w_data,
    input  logic [MASTER_DATA_WIDTH/8-1:0] master_w_strb,
    input  logic                           master_w_last,
    input  logic [USER_WIDTH-1:0]          master_w_user,
    input  logic                           master_w_valid,
    output logic                           master_w_ready,
    output logic [SLAVE_DATA_WIDTH-1:0]    slave_w_data,
    output logic [SLAVE_DATA_WIDTH/8-1:0]  slave_w_strb,
    output logic                           slave_w_last,
    output logic [USER_WIDTH-1:0]          slave_w_user,
    output logic                           slave_w_valid,
    input  logic                           slave_w_ready,
    output logic                           proto_err
);
    localparam int SC     = bytes_log2(SLAVE_DATA_WIDTH);
    localparam int MC     = bytes_log2(MASTER_DATA_WIDTH);
    localparam int LANE_W = (MC > SC) ? (MC - SC) : 1;
    localparam int MB     = MASTER_DATA_WIDTH / 8;

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [2:0]                     size_q, size_d;
    logic [7:0]                     len_q, len_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [MASTER_DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [MB-1:0]                  hold_strb_q, hold_strb_d;
    logic                           hold_last_q, hold_last_d;
    logic [USER_WIDTH-1:0]          hold_user_q, hold_user_d;

    logic [ADDR_WIDTH-1:0]          step;
    logic [ADDR_WIDTH-1:0]          next_addr;
    logic                           last_beat;
    logic                           need_new;
    logic                           slave_hs;
    logic [LANE_W-1:0]              lane;

    // Next narrow address: align down to the narrow step, then advance.
    assign step      = ADDR_WIDTH'(slave_step(size_q, SC));
    assign next_addr = (addr_q & ~(step - 1'b1)) + step;
    assign need_new  = need_new_beat(next_addr[7:0], size_q, SC);
    assign last_beat = (cnt_q == len_q);
    assign slave_hs  = (state_q == S_SEND) && slave_w_ready;

    generate
        if (MC == SC) begin : g_one_lane
            assign lane = '0;
        end else begin : g_lanes
            assign lane = addr_q[MC-1:SC];
        end
    endgenerate

    nasti_lane_select #(
        .IN_W   (MASTER_DATA_WIDTH),
        .OUT_W  (SLAVE_DATA_WIDTH),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .in_data  (hold_data_q),
        .in_strb  (hold_strb_q),
        .lane     (lane),
        .out_data (slave_w_data),
        .out_strb (slave_w_strb)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_strb_q <= '0;
            hold_last_q <= 1'b0;
            hold_user_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_strb_q <= hold_strb_d;
            hold_last_q <= hold_last_d;
            hold_user_q <= hold_user_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid)      state_d = S_LOAD;
            S_LOAD: if (master_w_valid) state_d = S_SEND;
            S_SEND: begin
                if (slave_w_ready) begin
                    if (last_beat)     state_d = S_IDLE;
                    else if (need_new) state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates.
    always_comb begin
        addr_d      = addr_q;
        size_d      = size_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_strb_d = hold_strb_q;
        hold_last_d = hold_last_q;
        hold_user_d = hold_user_q;
        if (state_q == S_IDLE && cmd_valid) begin
            addr_d = cmd_addr;
            size_d = cmd_size;
            len_d  = cmd_len;
            cnt_d  = '0;
        end
        if (state_q == S_LOAD && master_w_valid) begin
            hold_data_d = master_w_data;
            hold_strb_d = master_w_strb;
            hold_last_d = master_w_last;
            hold_user_d = master_w_user;
        end
        if (slave_hs) begin
            addr_d = next_addr;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    // Outputs.
    always_comb begin
        cmd_ready      = (state_q == S_IDLE);
        master_w_ready = (state_q == S_LOAD);
        slave_w_valid  = (state_q == S_SEND);
        slave_w_last   = (state_q == S_SEND) && last_beat;
        slave_w_user   = hold_user_q;
    end

`ifdef NASTI_NARROWER_W_CHECK_EN
    logic proto_err_q, proto_err_d;
    logic viol_early, viol_final;

    // Early: held beat claims last, yet the burst still needs another wide beat.
    // Final: the burst ends on a held beat that did not claim last.
    assign viol_early = slave_hs && !last_beat && need_new && hold_last_q;
    assign viol_final = slave_hs && last_beat && !hold_last_q;

    always_comb begin
        proto_err_d = proto_err_q | viol_early | viol_final;
    end

    always_ff @(posedge clk) begin
        if (!rstn) proto_err_q <= 1'b0;
        else       proto_err_q <= proto_err_d;
    end

    always_ff @(posedge clk) begin
        if (rstn && viol_early) $error("master_w_last asserted before the slave burst ends");
        if (rstn && viol_final) $error("slave burst ended on a master beat without last");
    end

    assign proto_err = proto_err_q;
`else
    logic unused_hold_last;
    assign unused_hold_last = hold_last_q;
    assign proto_err        = 1'b0;
`endif

endmodule

// File: tb/tb_nasti_narrower_w_splitter.sv
module tb_nasti_narrower_w_splitter;
    localparam int AW = 32, MDW = 64, SDW = 32, UW = 1;
    localparam int SC = 2, NL = MDW / SDW;
`ifdef NASTI_NARROWER_W_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk, rstn;
    logic [AW-1:0] cmd_addr;
    logic [2:0] cmd_size;
    logic [7:0] cmd_len;
    logic cmd_valid, cmd_ready;
    logic [MDW-1:0] master_w_data;
    logic [MDW/8-1:0] master_w_strb;
    logic master_w_last;
    logic [UW-1:0] master_w_user;
    logic master_w_valid, master_w_ready;
    logic [SDW-1:0] slave_w_data;
    logic [SDW/8-1:0] slave_w_strb;
    logic slave_w_last;
    logic [UW-1:0] slave_w_user;
    logic slave_w_valid, slave_w_ready;
    logic proto_err;

    nasti_narrower_w_splitter dut (
        .clk(clk), .rstn(rstn),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .master_w_data(master_w_data), .master_w_strb(master_w_strb),
        .master_w_last(master_w_last), .master_w_user(master_w_user),
        .master_w_valid(master_w_valid), .master_w_ready(master_w_ready),
        .slave_w_data(slave_w_data), .slave_w_strb(slave_w_strb),
        .slave_w_last(slave_w_last), .slave_w_user(slave_w_user),
        .slave_w_valid(slave_w_valid), .slave_w_ready(slave_w_ready),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SDW-1:0]   data;
        logic [SDW/8-1:0] strb;
        logic             last;
        logic [UW-1:0]    user;
        bit               viol;
    } beat_t;

    beat_t          exp_q[$];
    logic [SDW-1:0] obs_q[$];
    int  checks = 0, errors = 0;
    bit  chk_en = 1'b0;
    bit  exp_perr = 1'b0;
    int  hs_cnt = 0, mhs_cnt = 0;
    int  rdy_mode = 0;
    bit  bp_arm = 1'b0;
    int  bp_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Spec rule: new wide beat needed when size <= SC, or when the next
    // address sits at the first narrow lane of its size-aligned block.
    function automatic bit need_beat(input logic [31:0] an, input int size);
        if (size <= SC) return 1'b1;
        return ((an % (32'd1 << size)) >> SC) == 0;
    endfunction

    // Compare process: every cycle outside reset.
    logic [SDW-1:0] p_data;
    logic [SDW/8-1:0] p_strb;
    logic p_last;
    bit stall_prev = 1'b0, mhs_prev = 1'b0;

    always @(negedge clk) begin
        if (!rstn || !chk_en) begin
            stall_prev = 1'b0;
            mhs_prev   = 1'b0;
        end else begin
            if (mhs_prev) chk("latency_valid", 64'(slave_w_valid), 64'd1);
            if (stall_prev) begin
                chk("bp_valid", 64'(slave_w_valid), 64'd1);
                chk("bp_data", 64'(slave_w_data), 64'(p_data));
                chk("bp_strb", 64'(slave_w_strb), 64'(p_strb));
                chk("bp_last", 64'(slave_w_last), 64'(p_last));
            end
            chk("proto_err", 64'(proto_err), 64'(exp_perr));
            if (slave_w_valid) begin
                chk("no_mready_in_send", 64'(master_w_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_slave_valid actual=1 expected=0 t=%0t", $time);
                end else begin
                    chk("s_data", 64'(slave_w_data), 64'(exp_q[0].data));
                    chk("s_strb", 64'(slave_w_strb), 64'(exp_q[0].strb));
                    chk("s_last", 64'(slave_w_last), 64'(exp_q[0].last));
                    chk("s_user", 64'(slave_w_user), 64'(exp_q[0].user));
                    if (slave_w_ready) begin
                        if (CHK && exp_q[0].viol) exp_perr = 1'b1;
                        obs_q.push_back(slave_w_data);
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            stall_prev = slave_w_valid && !slave_w_ready;
            p_data = slave_w_data;
            p_strb = slave_w_strb;
            p_last = slave_w_last;
            mhs_prev = master_w_valid && master_w_ready;
            if (mhs_prev) mhs_cnt++;
        end
    end

    // Slave ready driver: 0 always ready, 1 random, 2 three-cycle stall after first beat.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: slave_w_ready = 1'b1;
            1: slave_w_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (bp_arm && hs_cnt == 1) begin
                    bp_left = 3;
                    bp_arm  = 1'b0;
                end
                slave_w_ready = (bp_left == 0);
                if (bp_left > 0) bp_left--;
            end
        endcase
    end

    task automatic send_cmd(input logic [31:0] a, input logic [2:0] s, input logic [7:0] l);
        bit hs = 1'b0;
        int n = 0;
        cmd_addr = a; cmd_size = s; cmd_len = l; cmd_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_handshake", 64'(hs), 64'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        chk_en = 1'b0;
        cmd_valid = 1'b0;
        master_w_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_mready", 64'(master_w_ready), 64'd0);
        chk("rst_svalid", 64'(slave_w_valid), 64'd0);
        chk("rst_slast", 64'(slave_w_last), 64'd0);
        chk("rst_perr", 64'(proto_err), 64'd0);
        chk("rst_sdata", 64'(slave_w_data), 64'd0);
        chk("rst_sstrb", 64'(slave_w_strb), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_perr = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
    endtask

    task automatic run_burst(input logic [31:0] addr, input int size, input int len,
                             input bit fixed, input logic [63:0] d0, input logic [63:0] d1,
                             input bit first_last);
        logic [31:0] ak[256];
        int          mk[256];
        logic [MDW-1:0]   mdata[256];
        logic [MDW/8-1:0] mstrb[256];
        logic             mlast[256];
        logic [UW-1:0]    muser[256];
        logic [31:0] a, stepv;
        int m, nb, n;
        bit hs;
        beat_t e;
        stepv = 32'd1 << ((size > SC) ? SC : size);
        a = addr;
        m = 0;
        for (int k = 0; k <= len; k++) begin
            ak[k] = a;
            mk[k] = m;
            if (k < len) begin
                a = (a & ~(stepv - 1)) + stepv;
                if (need_beat(a, size)) m++;
            end
        end
        nb = m + 1;
        for (int i = 0; i < nb; i++) begin
            mdata[i] = fixed ? ((i == 0) ? d0 : d1) : {$urandom, $urandom};
            mstrb[i] = 8'($urandom);
            muser[i] = UW'($urandom);
            mlast[i] = (i == nb - 1) || (first_last && i == 0);
        end
        for (int k = 0; k <= len; k++) begin
            int lane;
            lane   = int'((ak[k] >> SC) % NL);
            e.data = mdata[mk[k]][lane*SDW +: SDW];
            e.strb = mstrb[mk[k]][lane*(SDW/8) +: SDW/8];
            e.user = muser[mk[k]];
            e.last = (k == len);
            if (k < len) e.viol = (mk[k+1] != mk[k]) && mlast[mk[k]];
            else         e.viol = !mlast[mk[k]];
            exp_q.push_back(e);
        end
        hs_cnt = 0;
        mhs_cnt = 0;
        obs_q.delete();
        send_cmd(addr, 3'(size), 8'(len));
        for (int i = 0; i < nb; i++) begin
            if (rdy_mode == 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            master_w_data = mdata[i]; master_w_strb = mstrb[i];
            master_w_last = mlast[i]; master_w_user = muser[i];
            master_w_valid = 1'b1;
            hs = 1'b0;
            n = 0;
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = master_w_ready;
                @(posedge clk); #1;
                n++;
            end
            master_w_valid = 1'b0;
            chk("master_handshake", 64'(hs), 64'd1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("burst_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("master_beats", 64'(mhs_cnt), 64'(nb));
        @(negedge clk);
        chk("back_to_idle", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_len = '0;
        master_w_valid = 1'b0; master_w_data = '0; master_w_strb = '0;
        master_w_last = 1'b0; master_w_user = '0; slave_w_ready = 1'b1;
        do_reset();

        // Aligned full-width burst.
        rdy_mode = 0;
        run_burst(32'h1000, 3, 3, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
        chk("t1_count", 64'(obs_q.size()), 64'd4);
        if (obs_q.size() == 4) begin
            chk("t1_b0", 64'(obs_q[0]), 64'hCCCCDDDD);
            chk("t1_b1", 64'(obs_q[1]), 64'hAAAABBBB);
            chk("t1_b2", 64'(obs_q[2]), 64'h33334444);
            chk("t1_b3", 64'(obs_q[3]), 64'h11112222);
        end
        chk("t1_mbeats", 64'(mhs_cnt), 64'd2);

        // Unaligned start, single beat.
        run_burst(32'h1004, 3, 0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 1'b0);
        chk("t2_count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() == 1) chk("t2_b0", 64'(obs_q[0]), 64'hAAAABBBB);

        // Narrow master size: one wide beat per narrow beat.
        run_burst(32'h1004, 2, 1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
        chk("t3_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("t3_b0", 64'(obs_q[0]), 64'hAAAABBBB);
            chk("t3_b1", 64'(obs_q[1]), 64'h33334444);
        end
        chk("t3_mbeats", 64'(mhs_cnt), 64'd2);

        // Backpressure mid-burst.
        rdy_mode = 2;
        bp_arm = 1'b1;
        run_burst(32'h1000, 3, 3, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("bp_count", 64'(obs_q.size()), 64'd4);
        rdy_mode = 0;

        // Address wrap at top of address space.
        run_burst(32'hFFFF_FFF8, 3, 3, 1'b0, 64'h0, 64'h0, 1'b0);

        // Early master last: proto_err only with the check enabled.
        run_burst(32'h1000, 3, 3, 1'b0, 64'h0, 64'h0, 1'b1);
        @(negedge clk);
        chk("proto_sticky", 64'(proto_err), 64'(CHK));
        @(posedge clk); #1;
        do_reset();

        // Reset in the middle of a burst.
        chk_en = 1'b0;
        send_cmd(32'h1000, 3'd3, 8'd3);
        master_w_data = 64'h0123_4567_89AB_CDEF; master_w_strb = 8'hFF;
        master_w_last = 1'b0; master_w_valid = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (master_w_ready) n = 100;
            @(posedge clk); #1;
            n++;
        end
        master_w_valid = 1'b0;
        chk("mid_rst_load", 64'(n > 100), 64'd1);
        n = 0;
        for (int t = 0; t < 50 && n < 2; t++) begin
            @(negedge clk);
            if (slave_w_valid && slave_w_ready) n++;
            @(posedge clk); #1;
        end
        chk("mid_rst_two_beats", 64'(n), 64'd2);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_svalid", 64'(slave_w_valid), 64'd0);
        chk("mid_rst_mready", 64'(master_w_ready), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_slast", 64'(slave_w_last), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_perr = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
        run_burst(32'h1000, 3, 3, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
        if (obs_q.size() == 4) chk("post_rst_b3", 64'(obs_q[3]), 64'h11112222);

        // Randomized bursts with random gaps and backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            run_burst(32'h2000 + 32'($urandom_range(0, 255)), $urandom_range(0, 3),
                      $urandom_range(0, 15), 1'b0, 64'h0, 64'h0, 1'b0);
        end
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
